pipelined_adder: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor. It generalises the lab's fixed 4-bit ripple adder to WIDTH bits, split into STAGES carry-registered chunks, with add/subtract mode, a valid/ready handshake on both sides and optional status flags. It sits between operand registers (switch/datapath sources) and result consumers (LED/HEX display logic, accumulators) wherever a wide add must close timing at one result per cycle.

---
 rtl/pipelined_adder_if.sv | 28 ++
 rtl/pipelined_adder.sv | 113 +++++++++++
 tb/tb_pipelined_adder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// master = operand source and result consumer, slave = the adder.
interface pipelined_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor, WIDTH bits split into STAGES carry-registered chunks.
// Define PIPELINED_ADDER_FLAGS_EN to build the ovf/zero status flags; otherwise both read 0.
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    pipelined_adder_if.slave   bus
);
    localparam int C = WIDTH / STAGES;
    localparam int L = STAGES - 1;

    logic             w_adv;

    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             r_c [STAGES];
    logic             r_v [STAGES];

    logic [WIDTH-1:0] w_a_in [STAGES];
    logic [WIDTH-1:0] w_b_in [STAGES];
    logic [WIDTH-1:0] w_s_in [STAGES];
    logic             w_c_in [STAGES];
    logic             w_v_in [STAGES];
    logic [WIDTH-1:0] w_s_nx [STAGES];
    logic             w_c_nx [STAGES];
    logic [C:0]       w_chunk [STAGES];

    assign w_adv        = !r_v[L] || bus.out_ready;
    assign bus.in_ready = w_adv;

    // Stage k consumes the operands skewed in from stage k-1 and fills chunk k of the sum.
    always_comb begin
        w_a_in[0] = bus.a;
        w_b_in[0] = bus.sub ? ~bus.b : bus.b;
        w_c_in[0] = bus.sub | bus.cin;
        w_s_in[0] = '0;
        w_v_in[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_a_in[k] = r_a[k-1];
            w_b_in[k] = r_b[k-1];
            w_c_in[k] = r_c[k-1];
            w_s_in[k] = r_s[k-1];
            w_v_in[k] = r_v[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_chunk[k] = {1'b0, w_a_in[k][k*C +: C]}
                       + {1'b0, w_b_in[k][k*C +: C]}
                       + {{C{1'b0}}, w_c_in[k]};
            w_s_nx[k]            = w_s_in[k];
            w_s_nx[k][k*C +: C]  = w_chunk[k][C-1:0];
            w_c_nx[k]            = w_chunk[k][C];
        end
    end

    // Data only loads with a valid token, so bubbles leave the result fields untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= 1'b0;
                r_c[k] <= 1'b0;
                r_s[k] <= '0;
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= w_v_in[k];
                if (w_v_in[k]) begin
                    r_c[k] <= w_c_nx[k];
                    r_s[k] <= w_s_nx[k];
                    r_a[k] <= w_a_in[k];
                    r_b[k] <= w_b_in[k];
                end
            end
        end
    end

    assign bus.out_valid = r_v[L];
    assign bus.sum       = r_s[L];
    assign bus.cout      = r_c[L];

`ifdef PIPELINED_ADDER_FLAGS_EN
    logic r_ovf;
    logic r_zero;
    logic w_ovf_nx;
    logic w_zero_nx;

    // a^b'^sum at the MSB recovers the carry into the MSB.
    assign w_ovf_nx  = w_a_in[L][WIDTH-1] ^ w_b_in[L][WIDTH-1]
                     ^ w_s_nx[L][WIDTH-1] ^ w_c_nx[L];
    assign w_zero_nx = (w_s_nx[L] == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_adv && w_v_in[L]) begin
            r_ovf  <= w_ovf_nx;
            r_zero <= w_zero_nx;
        end
    end

    assign bus.ovf  = r_ovf;
    assign bus.zero = r_zero;
`else
    assign bus.ovf  = 1'b0;
    assign bus.zero = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and random checks of pipelined_adder at WIDTH=8, STAGES=2.
module tb_pipelined_adder;
    localparam int W = 8;
    localparam int S = 2;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       cin;
        logic [7:0] s;
        logic       c;
        logic       o;
        logic       z;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(W)) bus ();

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    vec_t stim_q[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic fl(input logic v);
`ifdef PIPELINED_ADDER_FLAGS_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic sub,
                                input logic cin, input logic [7:0] s, input logic c,
                                input logic o, input logic z);
        vec_t v;
        v.a = a; v.b = b; v.sub = sub; v.cin = cin;
        v.s = s; v.c = c; v.o = fl(o); v.z = fl(z);
        return v;
    endfunction

    function automatic vec_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic sub, input logic cin);
        vec_t v;
        logic [7:0] bb;
        logic [8:0] t;
        bb = sub ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + {8'd0, (sub ? 1'b1 : cin)};
        v.a = a; v.b = b; v.sub = sub; v.cin = cin;
        v.s = t[7:0];
        v.c = t[8];
        v.o = fl((a[7] == bb[7]) && (t[7] != a[7]));
        v.z = fl(t[7:0] == 8'd0);
        return v;
    endfunction

    task automatic drive_idle();
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.sub      = 1'b0;
        bus.cin      = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        bus.in_valid = 1'b1;
        bus.a        = v.a;
        bus.b        = v.b;
        bus.sub      = v.sub;
        bus.cin      = v.cin;
    endtask

    // mode 0: out_ready=1; mode 1: 3-cycle stall after first result; mode 2: random ready and bubbles
    task automatic run_stream(input int mode, input int budget);
        int stall_left = 0;
        bit stall_done = 1'b0;
        int cyc        = 0;
        vec_t e;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            if (mode == 1) begin
                if (bus.out_valid && !stall_done) begin
                    stall_left = 3;
                    stall_done = 1'b1;
                end
                bus.out_ready = (stall_left == 0);
            end else if (mode == 2) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.out_ready = 1'b1;
            end
            if (stim_q.size() > 0 && !(mode == 2 && $urandom_range(0, 4) == 0))
                drive_vec(stim_q[0]);
            else
                drive_idle();
            #1;
            if (stall_left > 0) begin
                chk("stall_in_ready", bus.in_ready, 0);
                chk("stall_out_valid", bus.out_valid, 1);
                if (exp_q.size() > 0) chk("stall_sum", bus.sum, exp_q[0].s);
                stall_left--;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum", bus.sum, e.s);
                    chk("cout", bus.cout, e.c);
                    chk("ovf", bus.ovf, e.o);
                    chk("zero", bus.zero, e.z);
                end
            end
            if (bus.in_valid && bus.in_ready) exp_q.push_back(stim_q.pop_front());
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        chk("stream_left", stim_q.size() + exp_q.size(), 0);
        stim_q.delete();
        exp_q.delete();
        drive_idle();
    endtask

    initial begin
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        drive_idle();
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_zero", bus.zero, 0);
        @(negedge clk);
        reset = 1'b0;

        // Latency: result visible exactly 2 edges after acceptance
        drive_vec(mk(8'h0F, 8'h01, 0, 0, 8'h10, 0, 0, 0));
        #1;
        chk("lat_in_ready", bus.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        #1;
        chk("lat_edge1_valid", bus.out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("lat_edge2_valid", bus.out_valid, 1);
        chk("lat_sum", bus.sum, 8'h10);
        chk("lat_cout", bus.cout, 0);
        chk("lat_ovf", bus.ovf, 0);
        chk("lat_zero", bus.zero, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("retired_valid", bus.out_valid, 0);
        chk("hold_sum", bus.sum, 8'h10);
        @(negedge clk);

        // Directed back-to-back vectors
        stim_q.push_back(mk(8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 1));
        stim_q.push_back(mk(8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, 0));
        stim_q.push_back(mk(8'h05, 8'h07, 1, 1, 8'hFE, 0, 0, 0));
        stim_q.push_back(mk(8'h80, 8'h01, 1, 0, 8'h7F, 1, 1, 0));
        stim_q.push_back(mk(8'h10, 8'h20, 0, 1, 8'h31, 0, 0, 0));
        run_stream(0, 50);

        // Backpressure: 5 transactions, 3-cycle stall after first result
        stim_q.push_back(mk(8'h01, 8'h02, 0, 0, 8'h03, 0, 0, 0));
        stim_q.push_back(mk(8'h10, 8'h10, 0, 1, 8'h21, 0, 0, 0));
        stim_q.push_back(mk(8'h40, 8'h40, 0, 0, 8'h80, 0, 1, 0));
        stim_q.push_back(mk(8'hC0, 8'hC0, 0, 0, 8'h80, 1, 0, 0));
        stim_q.push_back(mk(8'h33, 8'h33, 1, 0, 8'h00, 1, 0, 1));
        run_stream(1, 50);

        // Reset with two transactions in flight
        drive_vec(mk(8'h12, 8'h34, 0, 0, 8'h46, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        drive_vec(mk(8'h01, 8'h01, 0, 0, 8'h02, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_sum", bus.sum, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("post_rst_valid", bus.out_valid, 0);
            @(posedge clk);
            @(negedge clk);
        end
        stim_q.push_back(mk(8'hA5, 8'h5A, 0, 1, 8'h00, 1, 0, 1));
        run_stream(0, 20);

        // Random traffic with random backpressure and bubbles
        for (int i = 0; i < 200; i++)
            stim_q.push_back(model(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom)));
        run_stream(2, 5000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
